// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite memory slave: word-organised SRAM with byte/half/word lanes,
// programmable wait states and a two-cycle ERROR response.
// Read data is captured from the array at the accepting edge. A write that
// completes on that same edge is forwarded into the captured word so that a
// read right behind a write to the same word returns the merged data.
module ahb_lite_mem_slave #(
    parameter int MEM_DEPTH   = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic        H_clk,
    input  logic        H_rst,
    input  logic        H_sel,
    input  logic [31:0] H_add,
    input  logic        H_WR,
    input  logic [2:0]  H_size,
    input  logic [3:0]  H_burst,
    input  logic [1:0]  H_trans,
    input  logic [31:0] W_data,
    output logic [31:0] R_data,
    output logic        H_readyN,
    output logic        H_rsp
);

    localparam int          IDX_W       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [31:0] ADDR_LIMIT  = 32'(MEM_DEPTH * 4);
    localparam logic [2:0]  WAIT_CYCLES = 3'(WAIT_STATES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // Control state for the transfer currently in its data phase
    state_t      state_q,    state_d;
    logic [2:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] addr_q,     addr_d;
    logic        wr_q,       wr_d;
    logic [2:0]  size_q,     size_d;

    // Bytes of a completing write forwarded into a read captured on the same edge
    logic [3:0]  fwd_mask_q, fwd_mask_d;
    logic [31:0] fwd_data_q, fwd_data_d;

    // Storage and its registered read port
    logic [31:0] mem [MEM_DEPTH];
    logic [31:0] rd_word_q;

    logic             accept;
    logic             size_ok;
    logic             addr_ok;
    logic             align_ok;
    logic             legal;
    logic             mem_we;
    logic [3:0]       lane_mask;
    logic [31:0]      read_word;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;

    // Burst type and the low transfer bit carry no meaning for this slave
    logic unused_ok;
    assign unused_ok = ^{H_burst, H_trans[0]};

    // An address phase is taken only while the slave shows ready
    assign accept = H_readyN && H_sel && H_trans[1];
    assign rd_idx = H_add[IDX_W+1:2];
    assign wr_idx = addr_q[IDX_W+1:2];

    // Legality of the address phase currently on the bus
    always_comb begin
        size_ok  = (H_size <= 3'd2);
        addr_ok  = (H_add < ADDR_LIMIT);
        align_ok = 1'b1;
        if (H_size == 3'd1) begin
            align_ok = ~H_add[0];
        end else if (H_size == 3'd2) begin
            align_ok = (H_add[1:0] == 2'b00);
        end
        legal = size_ok && addr_ok && align_ok;
    end

    // Byte lanes touched by the transfer in its data phase
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_mask[gi] = (size_q == 3'd2)
                                || ((size_q == 3'd1) && (addr_q[1] == 1'(gi / 2)))
                                || ((size_q == 3'd0) && (addr_q[1:0] == 2'(gi)));
            assign read_word[gi*8 +: 8] = fwd_mask_q[gi] ? fwd_data_q[gi*8 +: 8]
                                                         : rd_word_q[gi*8 +: 8];
        end
    endgenerate

    // The write lands on the edge that closes a DATA cycle; reset discards it
    assign mem_we = (state_q == ST_DATA) && wr_q && !H_rst;

    // Next-state logic: transfer sequencing, wait counting and forwarding capture
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        size_d     = size_q;
        fwd_mask_d = fwd_mask_q;
        fwd_data_d = fwd_data_q;
        case (state_q)
            ST_WAIT: begin
                // Down-counter sticks at zero; leaving WAIT happens at zero
                if (wait_cnt_q == 3'd0) begin
                    state_d = ST_DATA;
                end else begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            default: begin
                // IDLE, DATA and ERR2 all show ready and may take a new address
                state_d    = ST_IDLE;
                wr_d       = 1'b0;
                fwd_mask_d = 4'b0000;
                if (accept) begin
                    addr_d = H_add;
                    wr_d   = H_WR;
                    size_d = H_size;
                    if (!legal) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_CYCLES != 3'd0) begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = WAIT_CYCLES - 3'd1;
                    end else begin
                        state_d = ST_DATA;
                    end
                    // Read of the word being written on this very edge
                    if (legal && !H_WR && mem_we && (H_add[31:2] == addr_q[31:2])) begin
                        fwd_mask_d = lane_mask;
                        fwd_data_d = W_data;
                    end
                end
            end
        endcase
    end

    // Control registers with synchronous reset
    always_ff @(posedge H_clk) begin
        if (H_rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 3'd0;
            addr_q     <= 32'h0;
            wr_q       <= 1'b0;
            size_q     <= 3'd0;
            fwd_mask_q <= 4'b0000;
            fwd_data_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            size_q     <= size_d;
            fwd_mask_q <= fwd_mask_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    // Array: byte-lane writes and a registered read taken at address acceptance
    always_ff @(posedge H_clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_mask[b]) begin
                    mem[wr_idx][b*8 +: 8] <= W_data[b*8 +: 8];
                end
            end
        end
        if (accept) begin
            rd_word_q <= mem[rd_idx];
        end
    end

    // Bus response decoded from the registered state only
    always_comb begin
        H_readyN = 1'b1;
        H_rsp    = 1'b0;
        R_data   = 32'h0;
        case (state_q)
            ST_WAIT: begin
                H_readyN = 1'b0;
            end
            ST_ERR1: begin
                H_readyN = 1'b0;
                H_rsp    = 1'b1;
            end
            ST_ERR2: begin
                H_rsp = 1'b1;
            end
            ST_DATA: begin
                if (!wr_q) begin
                    R_data = read_word;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
